// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control: state codes, opcodes,
// datapath select codes and the control-output bundle.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_R_EXEC    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_ADDI_EXEC = 4'd10,
        ST_ADDI_WB   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_legal = 1'b1;
            default:                                       op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Bundle between the main control unit (master) and the datapath it steers (slave).
interface mips_multicycle_control_if;

    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic [1:0] PCSource;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp,
               instr_done, illegal_op, state
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp,
               instr_done, illegal_op, state
    );

endinterface

// File: rtl/mips_ctrl_outdec.sv
// Moore output decoder: maps the current state (and mem_ready in the memory
// states) to the datapath control bundle.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_e state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    // Per-state control decode; unlisted fields stay 0
    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SL2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEM_ADDR, ST_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            // MemWrite stays up across stalls; the store retires only when memory accepts it
            ST_MEM_WRITE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            ST_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            ST_ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control: state register, next-state logic, lw/sw latch
// and sticky illegal-opcode flag; outputs decoded from state by mips_ctrl_outdec.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst_n,
    mips_multicycle_control_if.master         bus
);

    state_e state_r;
    logic   is_store_r;
    logic   illegal_op_r;
    ctrl_t  ctrl_s;
    ctrl_t  out_s;
    logic   decode_illegal_s;

    mips_ctrl_outdec u_outdec (
        .state     (state_r),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl_s)
    );

    // Flags the DECODE cycle of an unsupported opcode so it can retire immediately
    always_comb begin
        if (state_r == ST_DECODE) begin
            decode_illegal_s = !op_legal(bus.opcode);
        end else begin
            decode_illegal_s = 1'b0;
        end
    end

    // State sequencing, lw/sw selection latch and sticky illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_FETCH;
            is_store_r   <= 1'b0;
            illegal_op_r <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH:     state_r <= bus.mem_ready ? ST_DECODE : ST_FETCH;
                ST_DECODE: begin
                    // bit 3 is the only difference between lw and sw
                    is_store_r <= bus.opcode[3];
                    case (bus.opcode)
                        OP_LW, OP_SW: state_r <= ST_MEM_ADDR;
                        OP_RTYPE:     state_r <= ST_R_EXEC;
                        OP_BEQ:       state_r <= ST_BRANCH;
                        OP_J:         state_r <= ST_JUMP;
                        OP_ADDI:      state_r <= ST_ADDI_EXEC;
                        default: begin
                            state_r      <= ST_FETCH;
                            illegal_op_r <= 1'b1;
                        end
                    endcase
                end
                ST_MEM_ADDR:  state_r <= is_store_r ? ST_MEM_WRITE : ST_MEM_READ;
                ST_MEM_READ:  state_r <= bus.mem_ready ? ST_MEM_WB : ST_MEM_READ;
                ST_MEM_WRITE: state_r <= bus.mem_ready ? ST_FETCH : ST_MEM_WRITE;
                ST_R_EXEC:    state_r <= ST_R_WB;
                ST_ADDI_EXEC: state_r <= ST_ADDI_WB;
                default:      state_r <= ST_FETCH;
            endcase
        end
    end

    // Hold every enable low for the whole time reset is asserted
    always_comb begin
        if (rst_n) begin
            out_s            = ctrl_s;
            out_s.instr_done = ctrl_s.instr_done | decode_illegal_s;
        end else begin
            out_s = '0;
        end
    end

    // Drive the bus from the gated control bundle
    always_comb begin
        bus.PCWrite     = out_s.pc_write;
        bus.PCWriteCond = out_s.pc_write_cond;
        bus.IorD        = out_s.i_or_d;
        bus.MemRead     = out_s.mem_read;
        bus.MemWrite    = out_s.mem_write;
        bus.MemtoReg    = out_s.mem_to_reg;
        bus.IRWrite     = out_s.ir_write;
        bus.ALUSrcA     = out_s.alu_src_a;
        bus.RegWrite    = out_s.reg_write;
        bus.RegDst      = out_s.reg_dst;
        bus.PCSource    = out_s.pc_source;
        bus.ALUSrcB     = out_s.alu_src_b;
        bus.ALUOp       = out_s.alu_op;
        bus.instr_done  = out_s.instr_done;
        bus.illegal_op  = illegal_op_r;
        bus.state       = state_r;
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed, table-driven bench for mips_multicycle_control with hand-written
// reset-during-store sequence.
module tb_mips_multicycle_control;

    localparam logic [9:0] PCW  = 10'b10_0000_0000;
    localparam logic [9:0] PCWC = 10'b01_0000_0000;
    localparam logic [9:0] IORD = 10'b00_1000_0000;
    localparam logic [9:0] MRD  = 10'b00_0100_0000;
    localparam logic [9:0] MWR  = 10'b00_0010_0000;
    localparam logic [9:0] M2R  = 10'b00_0001_0000;
    localparam logic [9:0] IRW  = 10'b00_0000_1000;
    localparam logic [9:0] SRCA = 10'b00_0000_0100;
    localparam logic [9:0] RW   = 10'b00_0000_0010;
    localparam logic [9:0] RDST = 10'b00_0000_0001;
    localparam logic [9:0] NONE = 10'b00_0000_0000;

    typedef struct {
        logic [5:0] op;
        logic       mr;
        logic [3:0] st;
        logic [9:0] en;
        logic [1:0] pcsrc;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic       done;
        logic       ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mips_multicycle_control_if bus ();

    mips_multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [21:0] actual();
        return {bus.state, bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                bus.MemWrite, bus.MemtoReg, bus.IRWrite, bus.ALUSrcA, bus.RegWrite,
                bus.RegDst, bus.PCSource, bus.ALUSrcB, bus.ALUOp, bus.instr_done,
                bus.illegal_op};
    endfunction

    task automatic check(input string name, input int idx, input logic [21:0] want);
        logic [21:0] got;
        got = actual();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s[%0d]: got st=%0d en=%b pcsrc=%b srcb=%b aluop=%b done=%b ill=%b, want st=%0d en=%b pcsrc=%b srcb=%b aluop=%b done=%b ill=%b",
                     name, idx, got[21:18], got[17:8], got[7:6], got[5:4], got[3:2], got[1], got[0],
                     want[21:18], want[17:8], want[7:6], want[5:4], want[3:2], want[1], want[0]);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic mr, input logic [3:0] st,
                       input logic [9:0] en, input logic [1:0] pcsrc, input logic [1:0] srcb,
                       input logic [1:0] aluop, input logic done, input logic ill);
        vec_t v;
        v.op = op; v.mr = mr; v.st = st; v.en = en; v.pcsrc = pcsrc;
        v.srcb = srcb; v.aluop = aluop; v.done = done; v.ill = ill;
        vecs.push_back(v);
    endtask

    initial begin
        // R-type: FETCH, DECODE, R_EXEC, R_WB
        add(6'h00, 1'b1, 4'd0,  PCW | MRD | IRW, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
        add(6'h00, 1'b1, 4'd1,  NONE,            2'b00, 2'b11, 2'b00, 1'b0, 1'b0);
        add(6'h2B, 1'b0, 4'd6,  SRCA,            2'b00, 2'b00, 2'b10, 1'b0, 1'b0);
        add(6'h2B, 1'b1, 4'd7,  RW | RDST,       2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        // lw, two stall cycles in MEM_READ; opcode changes after DECODE
        add(6'h3F, 1'b1, 4'd0,  PCW | MRD | IRW, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
        add(6'h23, 1'b1, 4'd1,  NONE,            2'b00, 2'b11, 2'b00, 1'b0, 1'b0);
        add(6'h2B, 1'b1, 4'd2,  SRCA,            2'b00, 2'b10, 2'b00, 1'b0, 1'b0);
        add(6'h2B, 1'b0, 4'd3,  MRD | IORD,      2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        add(6'h2B, 1'b0, 4'd3,  MRD | IORD,      2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        add(6'h2B, 1'b1, 4'd3,  MRD | IORD,      2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        add(6'h00, 1'b1, 4'd4,  RW | M2R,        2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        // sw, one stall cycle in FETCH
        add(6'h00, 1'b0, 4'd0,  MRD,             2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
        add(6'h00, 1'b1, 4'd0,  PCW | MRD | IRW, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
        add(6'h2B, 1'b1, 4'd1,  NONE,            2'b00, 2'b11, 2'b00, 1'b0, 1'b0);
        add(6'h23, 1'b1, 4'd2,  SRCA,            2'b00, 2'b10, 2'b00, 1'b0, 1'b0);
        add(6'h23, 1'b1, 4'd5,  MWR | IORD,      2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        // beq (mem_ready low outside memory states must not matter)
        add(6'h00, 1'b1, 4'd0,  PCW | MRD | IRW, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
        add(6'h04, 1'b0, 4'd1,  NONE,            2'b00, 2'b11, 2'b00, 1'b0, 1'b0);
        add(6'h00, 1'b0, 4'd8,  SRCA | PCWC,     2'b01, 2'b00, 2'b01, 1'b1, 1'b0);
        // j
        add(6'h00, 1'b1, 4'd0,  PCW | MRD | IRW, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
        add(6'h02, 1'b1, 4'd1,  NONE,            2'b00, 2'b11, 2'b00, 1'b0, 1'b0);
        add(6'h00, 1'b1, 4'd9,  PCW,             2'b10, 2'b00, 2'b00, 1'b1, 1'b0);
        // illegal opcode retires in DECODE, flag visible from next cycle
        add(6'h00, 1'b1, 4'd0,  PCW | MRD | IRW, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
        add(6'h3F, 1'b1, 4'd1,  NONE,            2'b00, 2'b11, 2'b00, 1'b1, 1'b0);
        // addi with sticky illegal_op
        add(6'h00, 1'b1, 4'd0,  PCW | MRD | IRW, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1);
        add(6'h08, 1'b1, 4'd1,  NONE,            2'b00, 2'b11, 2'b00, 1'b0, 1'b1);
        add(6'h00, 1'b1, 4'd10, SRCA,            2'b00, 2'b10, 2'b00, 1'b0, 1'b1);
        add(6'h00, 1'b1, 4'd11, RW,              2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        // sw stalled in MEM_WRITE; reset lands here afterwards
        add(6'h00, 1'b1, 4'd0,  PCW | MRD | IRW, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1);
        add(6'h2B, 1'b1, 4'd1,  NONE,            2'b00, 2'b11, 2'b00, 1'b0, 1'b1);
        add(6'h23, 1'b1, 4'd2,  SRCA,            2'b00, 2'b10, 2'b00, 1'b0, 1'b1);
        add(6'h23, 1'b0, 4'd5,  MWR | IORD,      2'b00, 2'b00, 2'b00, 1'b0, 1'b1);

        rst_n = 1'b0;
        bus.opcode = 6'h00;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        check("reset", 0, 22'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.opcode    = vecs[i].op;
            bus.mem_ready = vecs[i].mr;
            #2;
            check("vec", i, {vecs[i].st, vecs[i].en, vecs[i].pcsrc, vecs[i].srcb,
                             vecs[i].aluop, vecs[i].done, vecs[i].ill});
            @(posedge clk);
            #3;
        end

        // Still stalled in MEM_WRITE, then reset mid-cycle with no clock edge
        bus.mem_ready = 1'b0;
        #1;
        check("mw_stall", 0, {4'd5, MWR | IORD, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1});
        rst_n = 1'b0;
        #1;
        check("rst_mid", 0, 22'd0);
        @(posedge clk);
        #3;
        check("rst_hold", 0, 22'd0);
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode = 6'h00;
        #1;
        check("post_rst", 0, {4'd0, PCW | MRD | IRW, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0});
        @(posedge clk);
        #3;
        check("post_rst", 1, {4'd1, NONE, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
